// File: rtl/bus_fabric.sv
// CPU-side bus fabric: region decode, per-region wait states, write strobes, registered read data.
// Optional: define BUS_WRITE_PROTECT_EN to honour RO_MASK and report violations on wp_fault.
module bus_fabric #(
  parameter int ADDRW = 16,
  parameter int DATAW = 8,
  parameter int SELW  = 1,
  parameter logic [4*(2**SELW)-1:0] WAITS   = '0,
  parameter logic [(2**SELW)-1:0]   RO_MASK = '0
) (
  input  logic                        clk_pix,
  input  logic                        rst_pix,
  input  logic [ADDRW-1:0]            cpu_addr,
  input  logic [DATAW-1:0]            cpu_dout,
  input  logic                        cpu_we,
  output logic [DATAW-1:0]            cpu_din,
  output logic                        cpu_rdy,
  output logic [(2**SELW)-1:0]        dev_sel,
  output logic [ADDRW-SELW-1:0]       dev_addr,
  output logic [DATAW-1:0]            dev_wdata,
  output logic                        dev_we,
  input  logic [DATAW*(2**SELW)-1:0]  dev_rdata,
  input  logic                        wp_clr,
  output logic                        wp_fault
);

  localparam int NREG = 2**SELW;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic [SELW-1:0]   r;
  logic [SELW-1:0]   reg_q;
  logic [3:0]        cnt;
  logic [3:0]        cnt_eff;
  logic [3:0]        cnt_nx;
  logic [3:0]        wait_r;
  logic              rdy;
  logic              ro_hit;
  logic              wp_q;
  logic              wp_nx;
  logic              unused_ok;
  logic [3:0]        wait_a  [NREG];
  logic [DATAW-1:0]  rdata_a [NREG];

  for (genvar i = 0; i < NREG; i++) begin : g_unpack
    assign wait_a[i]  = WAITS[4*i +: 4];
    assign rdata_a[i] = dev_rdata[DATAW*i +: DATAW];
  end

  assign dev_addr  = cpu_addr[ADDRW-SELW-1:0];
  assign dev_wdata = cpu_dout;
  assign wp_fault  = wp_q;
  assign unused_ok = ^{wp_clr, 1'b0};

  always_comb begin
    r       = cpu_addr[ADDRW-1 -: SELW];
    state   = (cnt == 4'd0) ? IDLE : WAIT;
    wait_r  = wait_a[r];
    // A region switch mid-stall restarts the count for the new region
    cnt_eff = (state == WAIT && reg_q == r) ? cnt : 4'd0;
    rdy     = (wait_r == 4'd0) || (cnt_eff == wait_r);
    cnt_nx  = rdy ? 4'd0 : cnt_eff + 4'd1;
`ifdef BUS_WRITE_PROTECT_EN
    ro_hit  = RO_MASK[r];
    wp_nx   = (rdy & cpu_we & ro_hit) | (wp_q & ~wp_clr);
`else
    ro_hit  = 1'b0;
    wp_nx   = 1'b0;
`endif
    cpu_rdy = rdy | rst_pix;
    dev_we  = rdy & cpu_we & ~ro_hit & ~rst_pix;
    dev_sel = '0;
    dev_sel[r] = 1'b1;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      cnt     <= 4'd0;
      reg_q   <= '0;
      cpu_din <= '0;
      wp_q    <= 1'b0;
    end else begin
      cnt  <= cnt_nx;
      wp_q <= wp_nx;
      if (!rdy)
        reg_q <= r;
      if (rdy && !cpu_we)
        cpu_din <= rdata_a[r];
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: a 4-region wait-state table plus a
// zero-wait 2-region instance for back-to-back and write-protect cases.
module tb_bus_fabric;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Instance A: SELW=1, no wait states, region 1 read-only
  logic        rst_a, we_a, clr_a;
  logic [15:0] addr_a;
  logic [7:0]  dout_a, din_a, wdata_a;
  logic        rdy_a, dwe_a, wpf_a;
  logic [1:0]  sel_a;
  logic [14:0] daddr_a;
  logic [15:0] rdata_a;

  bus_fabric #(.ADDRW(16), .DATAW(8), .SELW(1), .WAITS(8'h00),
               .RO_MASK(2'b10)) u_a (
    .clk_pix(clk_pix), .rst_pix(rst_a), .cpu_addr(addr_a),
    .cpu_dout(dout_a), .cpu_we(we_a), .cpu_din(din_a), .cpu_rdy(rdy_a),
    .dev_sel(sel_a), .dev_addr(daddr_a), .dev_wdata(wdata_a),
    .dev_we(dwe_a), .dev_rdata(rdata_a), .wp_clr(clr_a),
    .wp_fault(wpf_a));

  // Instance B: SELW=2, waits r0=2 r1=3 r2=3 r3=1
  logic        rst_b, we_b, clr_b;
  logic [15:0] addr_b;
  logic [7:0]  dout_b, din_b, wdata_b;
  logic        rdy_b, dwe_b, wpf_b;
  logic [3:0]  sel_b;
  logic [13:0] daddr_b;
  logic [31:0] rdata_b;

  bus_fabric #(.ADDRW(16), .DATAW(8), .SELW(2), .WAITS(16'h1332),
               .RO_MASK(4'b0000)) u_b (
    .clk_pix(clk_pix), .rst_pix(rst_b), .cpu_addr(addr_b),
    .cpu_dout(dout_b), .cpu_we(we_b), .cpu_din(din_b), .cpu_rdy(rdy_b),
    .dev_sel(sel_b), .dev_addr(daddr_b), .dev_wdata(wdata_b),
    .dev_we(dwe_b), .dev_rdata(rdata_b), .wp_clr(clr_b),
    .wp_fault(wpf_b));

  typedef struct {
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic        e_rdy;
    logic        e_we;
    logic [7:0]  e_din;
    logic [3:0]  e_sel;
  } vec_t;

  vec_t tv [19];

  task automatic step;
    @(posedge clk_pix);
    #1;
  endtask

`ifdef BUS_WRITE_PROTECT_EN
  localparam logic WP = 1'b1;
`else
  localparam logic WP = 1'b0;
`endif

  initial begin
    tv[0]  = '{1, 16'h8123, 8'h00, 0, 1, 0, 8'h00, 4'b0100};
    tv[1]  = '{0, 16'h8123, 8'h00, 0, 0, 0, 8'h00, 4'b0100};
    tv[2]  = '{0, 16'h8123, 8'h00, 0, 0, 0, 8'h00, 4'b0100};
    tv[3]  = '{0, 16'h8123, 8'h00, 0, 0, 0, 8'h00, 4'b0100};
    tv[4]  = '{0, 16'h8123, 8'h00, 0, 1, 0, 8'h00, 4'b0100};
    tv[5]  = '{0, 16'h0200, 8'h55, 1, 0, 0, 8'h82, 4'b0001};
    tv[6]  = '{0, 16'h0200, 8'h55, 1, 0, 0, 8'h82, 4'b0001};
    tv[7]  = '{0, 16'h0200, 8'h55, 1, 1, 1, 8'h82, 4'b0001};
    tv[8]  = '{0, 16'h4000, 8'h00, 0, 0, 0, 8'h82, 4'b0010};
    tv[9]  = '{0, 16'h4000, 8'h00, 0, 0, 0, 8'h82, 4'b0010};
    tv[10] = '{0, 16'hC000, 8'h00, 0, 0, 0, 8'h82, 4'b1000};
    tv[11] = '{0, 16'hC000, 8'h00, 0, 1, 0, 8'h82, 4'b1000};
    tv[12] = '{0, 16'h8123, 8'h00, 0, 0, 0, 8'hC3, 4'b0100};
    tv[13] = '{0, 16'h8123, 8'h00, 0, 0, 0, 8'hC3, 4'b0100};
    tv[14] = '{1, 16'h0200, 8'h55, 1, 1, 0, 8'hC3, 4'b0001};
    tv[15] = '{0, 16'h0200, 8'h55, 1, 0, 0, 8'h00, 4'b0001};
    tv[16] = '{0, 16'h0200, 8'h55, 1, 0, 0, 8'h00, 4'b0001};
    tv[17] = '{0, 16'h0200, 8'h55, 1, 1, 1, 8'h00, 4'b0001};
    tv[18] = '{0, 16'h8123, 8'h00, 0, 0, 0, 8'h00, 4'b0100};

    rdata_a = {8'hA9, 8'h11};
    rdata_b = {8'hC3, 8'h82, 8'h41, 8'h10};
    rst_a = 1; we_a = 1; clr_a = 0; addr_a = 16'h0000; dout_a = 8'h33;
    rst_b = 1; we_b = 0; clr_b = 0; addr_b = 16'h0000; dout_b = 8'h00;
    step();
    step();

    @(negedge clk_pix);
    check("a_rst_rdy", 32'(rdy_a), 32'd1);
    check("a_rst_we", 32'(dwe_a), 32'd0);
    check("a_rst_din", 32'(din_a), 32'h00);
    check("a_rst_wp", 32'(wpf_a), 32'd0);
    check("b_rst_din", 32'(din_b), 32'h00);
    step();

    // Table-driven wait-state sequence on instance B
    for (int i = 0; i < 19; i++) begin
      rst_b = tv[i].rst; addr_b = tv[i].addr;
      dout_b = tv[i].dout; we_b = tv[i].we;
      @(negedge clk_pix);
      check($sformatf("b_rdy[%0d]", i), 32'(rdy_b), 32'(tv[i].e_rdy));
      check($sformatf("b_we[%0d]", i), 32'(dwe_b), 32'(tv[i].e_we));
      check($sformatf("b_din[%0d]", i), 32'(din_b), 32'(tv[i].e_din));
      check($sformatf("b_sel[%0d]", i), 32'(sel_b), 32'(tv[i].e_sel));
      check($sformatf("b_addr[%0d]", i), 32'(daddr_b),
            32'(tv[i].addr[13:0]));
      check($sformatf("b_wdata[%0d]", i), 32'(wdata_b),
            32'(tv[i].dout));
      check($sformatf("b_wp[%0d]", i), 32'(wpf_b), 32'd0);
      step();
    end

    // Instance A: zero-wait reads back to back
    rst_a = 0; we_a = 0; addr_a = 16'h8000;
    @(negedge clk_pix);
    check("a_rd1_rdy", 32'(rdy_a), 32'd1);
    check("a_rd1_sel", 32'(sel_a), 32'b10);
    check("a_rd1_din_before", 32'(din_a), 32'h00);
    step();
    addr_a = 16'h0000;
    @(negedge clk_pix);
    check("a_rd1_din", 32'(din_a), 32'hA9);
    check("a_rd2_rdy", 32'(rdy_a), 32'd1);
    check("a_rd2_sel", 32'(sel_a), 32'b01);
    step();

    // Write to read-only region
    we_a = 1; addr_a = 16'h8000; dout_a = 8'h77;
    @(negedge clk_pix);
    check("a_din_b2b", 32'(din_a), 32'h11);
    check("a_ro_we", 32'(dwe_a), 32'(!WP));
    check("a_ro_wdata", 32'(wdata_a), 32'h77);
    step();
    we_a = 0; addr_a = 16'h0000;
    @(negedge clk_pix);
    check("a_wp_set", 32'(wpf_a), 32'(WP));
    step();
    @(negedge clk_pix);
    check("a_wp_sticky", 32'(wpf_a), 32'(WP));
    clr_a = 1; we_a = 1; addr_a = 16'h8000;
    step();
    @(negedge clk_pix);
    check("a_wp_set_wins", 32'(wpf_a), 32'(WP));
    we_a = 0; addr_a = 16'h0000;
    step();
    @(negedge clk_pix);
    check("a_wp_clr", 32'(wpf_a), 32'd0);
    clr_a = 0; we_a = 1; dout_a = 8'h5A;
    @(negedge clk_pix);
    check("a_rw_we", 32'(dwe_a), 32'd1);
    step();
    we_a = 0;
    @(negedge clk_pix);
    check("a_we_one_cycle", 32'(dwe_a), 32'd0);
    check("a_wp_stays_clr", 32'(wpf_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_fabric.md
# bus_fabric

Parametrised CPU-side bus fabric that replaces the fixed one-bit ROM/RAM split between the 6502 core and its memories. It decodes the top address bits into 2**SELW regions, inserts per-region wait states by dropping `cpu_rdy`, issues single-cycle write strobes, and returns registered read data on the CPU data-in port. It sits between `cpu6502` and the ROM, RAM and peripheral blocks; the PPU side ports of those memories are untouched.

## Interface
Parameters:
- `ADDRW`, 16: CPU address width.
- `DATAW`, 8: data width.
- `SELW`, 1: region-select bits taken from `cpu_addr[ADDRW-1 -: SELW]`; NREG = 2**SELW.
- `WAITS`, 0: packed NREG×4-bit wait-state counts, region r at `[4r+3:4r]`; 0..15.
- `RO_MASK`, 0: NREG-bit read-only flags, bit r = region r (used only with `BUS_WRITE_PROTECT_EN`).

Ports:
- `clk_pix` in 1: single clock for the whole fabric.
- `rst_pix` in 1: reset, synchronous, active-high.
- `cpu_addr` in ADDRW: CPU address bus.
- `cpu_dout` in DATAW: CPU write data.
- `cpu_we` in 1: CPU write enable.
- `cpu_din` out DATAW: registered read data to CPU.
- `cpu_rdy` out 1: ready to CPU; low = stall.
- `dev_sel` out NREG: one-hot region select, combinational from `cpu_addr`.
- `dev_addr` out ADDRW-SELW: `cpu_addr` with select bits stripped.
- `dev_wdata` out DATAW: equals `cpu_dout`.
- `dev_we` out 1: write strobe, one cycle per completed write.
- `dev_rdata` in NREG×DATAW: packed read data, region r at `[DATAW*r +: DATAW]`.
- `wp_clr` in 1: clears `wp_fault`.
- `wp_fault` out 1: sticky write-protect violation.

## Operation
- Region r = `cpu_addr[ADDRW-1 -: SELW]`; `dev_sel` = 1<<r every cycle (also during stalls).
- Wait counter `cnt` (4 bits). State IDLE when `cnt`==0, WAIT otherwise.
- `cpu_rdy` = 1 when `WAITS[r]`==0 or `cnt`==`WAITS[r]`; else 0. Forced 1 while `rst_pix`.
- Stalled cycle (`cpu_rdy`=0): `cnt` <= `cnt`+1. Completing cycle (`cpu_rdy`=1): `cnt` <= 0.
- `cnt` is also cleared if region r differs from the region latched at stall start (`reg_q`); counting restarts for the new region.
- Completing cycle, `cpu_we`=1: `dev_we`=1 (combinational), exactly one cycle. Stalled cycles: `dev_we`=0.
- Completing cycle, `cpu_we`=0: `cpu_din` <= `dev_rdata[r]` at that edge. Otherwise `cpu_din` holds.
- Devices must present valid `dev_rdata` by the completing cycle; wait states cover slow devices.

## Timing
- Reset values: `cpu_din`=0, `cnt`=0, `reg_q`=0, `wp_fault`=0; `dev_we`=0 and `cpu_rdy`=1 during reset.
- Read latency: WAITS[r]+1 cycles from address presentation to `cpu_din` update.
- Zero-wait region: `cpu_rdy` never drops; back-to-back accesses every cycle.
- N-wait region: `cpu_rdy` low exactly N cycles, high on cycle N+1 (completing).
- Reset mid-wait: next cycle `cnt`=0, `cpu_rdy`=1; no `dev_we` emitted for the aborted access.
- `wp_clr` and a new violation in the same cycle: set wins.

## Configuration
- `BUS_WRITE_PROTECT_EN` defined: a completing write to region r with `RO_MASK[r]`=1 suppresses `dev_we` and sets `wp_fault` on the next edge; wait states still apply; `wp_clr` clears it.
- Undefined: `RO_MASK` ignored, all writes strobe `dev_we`, `wp_fault` tied 0, `wp_clr` unused.

## Test plan
- SELW=1, WAITS=0: read 0x8000 with `dev_rdata[1]`=0xA9 -> `cpu_rdy` stays 1, `cpu_din`=0xA9 one edge later, `dev_sel`=2'b10.
- SELW=2, WAITS region 2 = 3: read 0x8123 -> `cpu_rdy` low 3 cycles, high on 4th, `cpu_din` updates on that edge only, `dev_addr`=0x0123.
- Write 0x55 to 0x0200 in 2-wait region -> `dev_we` high exactly one cycle (third cycle), `dev_wdata`=0x55.
- `rst_pix` asserted at stall cycle 2 of 5 -> next cycle `cnt`=0, `cpu_rdy`=1, no `dev_we`, `cpu_din`=0.
- Region change mid-stall (0x4000 3-wait -> 0xC000 1-wait) -> counter restarts, `cpu_rdy` low 1 cycle then high.
- With `BUS_WRITE_PROTECT_EN`, `RO_MASK`=2'b10: write to 0x8000 -> no `dev_we`, `wp_fault`=1 until `wp_clr`; same write without macro -> `dev_we` pulses, `wp_fault`=0.
